adder_bist_ctrl: RTL and testbench
==================================

ADDER_BIST_CTRL -- requirements
Module: adder_bist_ctrl

Interface
REQ-001 SHALL have parameter SETTLE_CYCLES, default 1, range 1..15: cycles each vector is held before its result is sampled.
REQ-002 SHALL have port CLK, input, 1: single rising-edge clock.
REQ-003 SHALL have port RST_N, input, 1: asynchronous active-low reset.
REQ-004 SHALL have port START, input, 1: level-sampled run request.
REQ-005 SHALL have port ABORT, input, 1: stop the current run.
REQ-006 SHALL have ports A, B, output, 4 each: operands driven to the adder under test.
REQ-007 SHALL have port CIN, output, 1: carry-in driven to the adder under test.
REQ-008 SHALL have port SUM, input, 4: sum returned by the adder under test.
REQ-009 SHALL have port CARRY, input, 1: carry-out returned by the adder under test.
REQ-010 SHALL have status outputs BUSY (1), DONE (1), PASS (1) and ERR_COUNT (10).

Function
REQ-011 SHALL run a finite state machine with states IDLE, DRIVE, CHECK and FINISH.
REQ-012 SHALL use a 9-bit vector index {A,B,CIN}, with CIN as the LSB, which drives A/B/CIN directly from registers; all 512 combinations are applied in ascending order.
REQ-013 SHALL move from IDLE or FINISH to DRIVE on START=1, clearing the index, ERR_COUNT, DONE and PASS.
REQ-014 SHALL stay in DRIVE for SETTLE_CYCLES cycles, then spend 1 cycle in CHECK, giving each vector SETTLE_CYCLES+1 cycles.
REQ-015 SHALL, at the CHECK edge, compare {CARRY,SUM} against the 5-bit value A+B+CIN and increment ERR_COUNT by 1 on mismatch.
REQ-016 SHALL, after CHECK of index 511, enter FINISH; otherwise increment the index and return to DRIVE.
REQ-017 SHALL make a full run take 512*(SETTLE_CYCLES+1) cycles from the first DRIVE cycle to the FINISH entry; with the default this is 1024 cycles.
REQ-018 SHALL hold DONE=1 while in FINISH, and hold PASS=1 only when DONE=1 and ERR_COUNT=0.
REQ-019 SHALL keep BUSY=1 exactly while in DRIVE or CHECK.
REQ-020 SHALL ignore START while BUSY=1.
REQ-021 SHALL, on ABORT=1 while BUSY, go to IDLE next cycle with DONE=0 and PASS=0 while retaining ERR_COUNT.
REQ-022 SHALL give ABORT priority over START and over comparison in the same cycle.
REQ-023 SHALL never wrap or saturate ERR_COUNT, since the maximum value is 512 and it fits in 10 bits.

Reset
REQ-024 SHALL, while RST_N=0, asynchronously force state IDLE, index 0, A=0, B=0, CIN=0, BUSY=0, DONE=0, PASS=0, ERR_COUNT=0 and all capture registers to 0.
REQ-025 SHALL, on reset mid-run, discard all progress, and SHALL require a new START to begin a run after reset is released.

Configuration
REQ-026 SHALL, when macro BIST_FAIL_CAPTURE_EN is defined, add outputs FAIL_VALID (1), FAIL_A (4), FAIL_B (4), FAIL_CIN (1), FAIL_SUM (4) and FAIL_CARRY (1).
REQ-027 SHALL, with that macro defined, record the stimulus and the observed SUM/CARRY of the first mismatch of a run, set FAIL_VALID, and keep these values unchanged until the next START or reset.
REQ-028 SHALL, without the macro, omit those ports and registers entirely, with all other behaviour identical.

Structure
REQ-029 SHALL take the following from package adder_bist_pkg: the state enum, WIDTH=4, NUM_VECTORS=512 and ERR_W=10.
REQ-030 SHALL place the golden-model comparison in the single sub-module adder_bist_checker (inputs A, B, CIN, SUM, CARRY; output MISMATCH), with the FSM in the top level.

Verification
REQ-031 SHALL cover: correct adder connected, START pulsed -> DONE=1 after 1024 cycles, PASS=1, ERR_COUNT=0.
REQ-032 SHALL cover: SUM[0] stuck at 0 -> DONE=1, PASS=0, ERR_COUNT=256; with the macro, FAIL_A=0, FAIL_B=0, FAIL_CIN=1, FAIL_SUM=0, FAIL_CARRY=0.
REQ-033 SHALL cover: CARRY stuck at 0 -> ERR_COUNT=256, PASS=0.
REQ-034 SHALL cover: ABORT at cycle 100 -> BUSY=0 next cycle, DONE=0; a subsequent START yields a full clean run with PASS=1.
REQ-035 SHALL cover: RST_N low at cycle 300 -> all outputs 0 immediately; after release the block stays IDLE until START.
REQ-036 SHALL cover: SETTLE_CYCLES=3 with a correct adder -> DONE after 2048 cycles, PASS=1, and START pulses during the run ignored.

Source files
------------

// File: rtl/adder_bist_pkg.sv
// Shared types and sizes for the 4-bit adder BIST controller.
package adder_bist_pkg;

    localparam int WIDTH       = 4;
    localparam int NUM_VECTORS = 512;
    localparam int ERR_W       = 10;
    localparam int IDX_W       = 2 * WIDTH + 1;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DRIVE  = 2'd1,
        ST_CHECK  = 2'd2,
        ST_FINISH = 2'd3
    } bist_state_e;

endpackage

// File: rtl/adder_bist_ctrl_if.sv
// Stimulus/response bus between the BIST controller and the adder under test.
interface adder_bist_ctrl_if;
    import adder_bist_pkg::*;

    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic [WIDTH-1:0] sum;
    logic             carry;

    modport master (output a, output b, output cin, input sum, input carry);
    modport slave  (input a, input b, input cin, output sum, output carry);

endinterface

// File: rtl/adder_bist_checker.sv
// Golden-model comparison of the adder response against A+B+CIN.
module adder_bist_checker
    import adder_bist_pkg::*;
(
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic             cin_i,
    input  logic [WIDTH-1:0] sum_i,
    input  logic             carry_i,
    output logic             mismatch_o
);

    logic [WIDTH:0] golden;

    assign golden     = {1'b0, a_i} + {1'b0, b_i} + {{WIDTH{1'b0}}, cin_i};
    assign mismatch_o = ({carry_i, sum_i} != golden);

endmodule

// File: rtl/adder_bist_ctrl.sv
// Exhaustive BIST sequencer for a 4-bit adder; optional first-failure capture
// is compiled in when BIST_FAIL_CAPTURE_EN is defined.
//
// state     | meaning
// ST_IDLE   | waiting for START
// ST_DRIVE  | current vector held on A/B/CIN while the adder settles
// ST_CHECK  | response compared at the end of this cycle
// ST_FINISH | all 512 vectors applied, DONE/PASS valid
module adder_bist_ctrl
    import adder_bist_pkg::*;
#(
    parameter int SETTLE_CYCLES = 1
) (
    input  logic              clk_i,
    input  logic              rst_n_i,
    input  logic              start_i,
    input  logic              abort_i,
    adder_bist_ctrl_if.master dut_if,
    output logic              busy_o,
    output logic              done_o,
    output logic              pass_o,
    output logic [ERR_W-1:0]  err_count_o
`ifdef BIST_FAIL_CAPTURE_EN
    ,
    output logic              fail_valid_o,
    output logic [WIDTH-1:0]  fail_a_o,
    output logic [WIDTH-1:0]  fail_b_o,
    output logic              fail_cin_o,
    output logic [WIDTH-1:0]  fail_sum_o,
    output logic              fail_carry_o
`endif
);

    localparam logic [3:0]       SETTLE_LOAD = 4'(SETTLE_CYCLES - 1);
    localparam logic [IDX_W-1:0] LAST_IDX    = IDX_W'(NUM_VECTORS - 1);

    bist_state_e      state_q;
    logic [IDX_W-1:0] idx_q;
    logic [3:0]       settle_q;
    logic [ERR_W-1:0] err_q;
    logic             busy_q;
    logic             done_q;
    logic             pass_q;
    logic             mismatch;

`ifdef BIST_FAIL_CAPTURE_EN
    logic             fail_valid_q;
    logic [WIDTH-1:0] fail_a_q;
    logic [WIDTH-1:0] fail_b_q;
    logic             fail_cin_q;
    logic [WIDTH-1:0] fail_sum_q;
    logic             fail_carry_q;
`endif

    // Index packs {A,B,CIN} so ascending order walks CIN fastest.
    assign dut_if.a   = idx_q[2*WIDTH:WIDTH+1];
    assign dut_if.b   = idx_q[WIDTH:1];
    assign dut_if.cin = idx_q[0];

    adder_bist_checker u_checker (
        .a_i        (dut_if.a),
        .b_i        (dut_if.b),
        .cin_i      (dut_if.cin),
        .sum_i      (dut_if.sum),
        .carry_i    (dut_if.carry),
        .mismatch_o (mismatch)
    );

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q      <= ST_IDLE;
            idx_q        <= '0;
            settle_q     <= '0;
            err_q        <= '0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            pass_q       <= 1'b0;
`ifdef BIST_FAIL_CAPTURE_EN
            fail_valid_q <= 1'b0;
            fail_a_q     <= '0;
            fail_b_q     <= '0;
            fail_cin_q   <= 1'b0;
            fail_sum_q   <= '0;
            fail_carry_q <= 1'b0;
`endif
        end else begin
            case (state_q)
                ST_IDLE, ST_FINISH: begin
                    if (start_i) begin
                        state_q      <= ST_DRIVE;
                        idx_q        <= '0;
                        settle_q     <= SETTLE_LOAD;
                        err_q        <= '0;
                        busy_q       <= 1'b1;
                        done_q       <= 1'b0;
                        pass_q       <= 1'b0;
`ifdef BIST_FAIL_CAPTURE_EN
                        fail_valid_q <= 1'b0;
                        fail_a_q     <= '0;
                        fail_b_q     <= '0;
                        fail_cin_q   <= 1'b0;
                        fail_sum_q   <= '0;
                        fail_carry_q <= 1'b0;
`endif
                    end
                end
                ST_DRIVE: begin
                    if (abort_i) begin
                        state_q <= ST_IDLE;
                        idx_q   <= '0;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b0;
                        pass_q  <= 1'b0;
                    end else if (settle_q == 4'd0) begin
                        state_q <= ST_CHECK;
                    end else begin
                        settle_q <= settle_q - 4'd1;
                    end
                end
                ST_CHECK: begin
                    // Abort wins over the comparison in the same cycle.
                    if (abort_i) begin
                        state_q <= ST_IDLE;
                        idx_q   <= '0;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b0;
                        pass_q  <= 1'b0;
                    end else begin
                        if (mismatch) begin
                            err_q <= err_q + ERR_W'(1);
                        end
`ifdef BIST_FAIL_CAPTURE_EN
                        if (mismatch && !fail_valid_q) begin
                            fail_valid_q <= 1'b1;
                            fail_a_q     <= dut_if.a;
                            fail_b_q     <= dut_if.b;
                            fail_cin_q   <= dut_if.cin;
                            fail_sum_q   <= dut_if.sum;
                            fail_carry_q <= dut_if.carry;
                        end
`endif
                        if (idx_q == LAST_IDX) begin
                            state_q <= ST_FINISH;
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                            pass_q  <= (err_q == '0) && !mismatch;
                        end else begin
                            state_q  <= ST_DRIVE;
                            idx_q    <= idx_q + IDX_W'(1);
                            settle_q <= SETTLE_LOAD;
                        end
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign busy_o      = busy_q;
    assign done_o      = done_q;
    assign pass_o      = pass_q;
    assign err_count_o = err_q;

`ifdef BIST_FAIL_CAPTURE_EN
    assign fail_valid_o = fail_valid_q;
    assign fail_a_o     = fail_a_q;
    assign fail_b_o     = fail_b_q;
    assign fail_cin_o   = fail_cin_q;
    assign fail_sum_o   = fail_sum_q;
    assign fail_carry_o = fail_carry_q;
`endif

endmodule

// File: tb/tb_adder_bist_ctrl.sv
// Directed bench for adder_bist_ctrl: default-settle and SETTLE_CYCLES=3 instances,
// each checked every cycle against a cycle-count model of the run.
module tb_adder_bist_ctrl;
    import adder_bist_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n;
    logic       start_s [2];
    logic       abort_s [2];
    int         fault_s [2];
    logic       busy_s  [2];
    logic       done_s  [2];
    logic       pass_s  [2];
    logic [9:0] err_s   [2];

    int n_vec   = 0;
    int n_bad   = 0;
    int n_print = 0;

    adder_bist_ctrl_if if0 ();
    adder_bist_ctrl_if if1 ();

`ifdef BIST_FAIL_CAPTURE_EN
    logic       fv   [2];
    logic [3:0] fa   [2];
    logic [3:0] fb   [2];
    logic       fc   [2];
    logic [3:0] fs   [2];
    logic       fco  [2];
`endif

    adder_bist_ctrl dut0 (
        .clk_i       (clk),
        .rst_n_i     (rst_n),
        .start_i     (start_s[0]),
        .abort_i     (abort_s[0]),
        .dut_if      (if0),
        .busy_o      (busy_s[0]),
        .done_o      (done_s[0]),
        .pass_o      (pass_s[0]),
        .err_count_o (err_s[0])
`ifdef BIST_FAIL_CAPTURE_EN
        ,
        .fail_valid_o (fv[0]),
        .fail_a_o     (fa[0]),
        .fail_b_o     (fb[0]),
        .fail_cin_o   (fc[0]),
        .fail_sum_o   (fs[0]),
        .fail_carry_o (fco[0])
`endif
    );

    adder_bist_ctrl #(.SETTLE_CYCLES(3)) dut1 (
        .clk_i       (clk),
        .rst_n_i     (rst_n),
        .start_i     (start_s[1]),
        .abort_i     (abort_s[1]),
        .dut_if      (if1),
        .busy_o      (busy_s[1]),
        .done_o      (done_s[1]),
        .pass_o      (pass_s[1]),
        .err_count_o (err_s[1])
`ifdef BIST_FAIL_CAPTURE_EN
        ,
        .fail_valid_o (fv[1]),
        .fail_a_o     (fa[1]),
        .fail_b_o     (fb[1]),
        .fail_cin_o   (fc[1]),
        .fail_sum_o   (fs[1]),
        .fail_carry_o (fco[1])
`endif
    );

    // Adder under test: 0 = correct, 1 = SUM[0] stuck at 0, 2 = CARRY stuck at 0.
    function automatic logic [4:0] adder_out(logic [8:0] v, int f);
        logic [4:0] s;
        s = 5'(v[8:5]) + 5'(v[4:1]) + 5'(v[0]);
        if (f == 1) s[0] = 1'b0;
        else if (f == 2) s[4] = 1'b0;
        return s;
    endfunction

    function automatic bit is_bad(int v, int f);
        logic [8:0] vv;
        vv = 9'(v);
        return adder_out(vv, f) != adder_out(vv, 0);
    endfunction

    always_comb {if0.carry, if0.sum} = adder_out({if0.a, if0.b, if0.cin}, fault_s[0]);
    always_comb {if1.carry, if1.sum} = adder_out({if1.a, if1.b, if1.cin}, fault_s[1]);

    // Run model: cycles elapsed since the START edge determine the vector and check points.
    int sc    [2] = '{1, 3};
    bit act_m [2];
    bit done_m[2];
    int t_m   [2];
    int err_m [2];

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < 2; k++) begin
                act_m[k]  <= 1'b0;
                done_m[k] <= 1'b0;
                t_m[k]    <= 0;
                err_m[k]  <= 0;
            end
        end else begin
            for (int k = 0; k < 2; k++) begin
                if (act_m[k]) begin
                    if (abort_s[k]) begin
                        act_m[k] <= 1'b0;
                    end else begin
                        t_m[k] <= t_m[k] + 1;
                        if (t_m[k] % (sc[k] + 1) == sc[k]) begin
                            if (is_bad(t_m[k] / (sc[k] + 1), fault_s[k])) err_m[k] <= err_m[k] + 1;
                            if (t_m[k] / (sc[k] + 1) == 511) begin
                                act_m[k]  <= 1'b0;
                                done_m[k] <= 1'b1;
                            end
                        end
                    end
                end else if (start_s[k]) begin
                    act_m[k]  <= 1'b1;
                    done_m[k] <= 1'b0;
                    t_m[k]    <= 0;
                    err_m[k]  <= 0;
                end
            end
        end
    end

    always @(negedge clk) begin
        for (int k = 0; k < 2; k++) begin
            int abc;
            bit bad;
            abc = (k == 0) ? int'({if0.a, if0.b, if0.cin}) : int'({if1.a, if1.b, if1.cin});
            bad = (busy_s[k] !== act_m[k]) || (done_s[k] !== done_m[k]) ||
                  (pass_s[k] !== (done_m[k] && err_m[k] == 0)) || (int'(err_s[k]) != err_m[k]) ||
                  (act_m[k] && abc != t_m[k] / (sc[k] + 1));
            n_vec++;
            if (bad) begin
                n_bad++;
                if (n_print < 30) begin
                    n_print++;
                    $display("FAIL model_dut%0d t=%0t: got busy=%0b done=%0b pass=%0b err=%0d abc=%0d, want busy=%0b done=%0b err=%0d abc=%0d",
                             k, $time, busy_s[k], done_s[k], pass_s[k], err_s[k], abc,
                             act_m[k], done_m[k], err_m[k], t_m[k] / (sc[k] + 1));
                end
            end
        end
    end

    task automatic check(string name, int got, int want);
        n_vec++;
        if (got != want) begin
            n_bad++;
            $display("FAIL %s: got %0d, want %0d", name, got, want);
        end
    endtask

    task automatic run_start(int k);
        @(negedge clk);
        start_s[k] = 1'b1;
        @(negedge clk);
        start_s[k] = 1'b0;
    endtask

    task automatic wait_done(int k, int budget, output int n);
        n = 0;
        while (!done_s[k] && n < budget) begin
            @(negedge clk);
            n++;
        end
        if (!done_s[k]) begin
            n_vec++;
            n_bad++;
            $display("FAIL timeout_dut%0d: got no DONE after %0d cycles, want DONE", k, n);
        end
    endtask

    initial begin
        int n;
        rst_n = 1'b0;
        for (int k = 0; k < 2; k++) begin
            start_s[k] = 1'b0;
            abort_s[k] = 1'b0;
            fault_s[k] = 0;
        end
        repeat (2) @(negedge clk);
        check("rst_busy", int'(busy_s[0]), 0);
        check("rst_done", int'(done_s[0]), 0);
        check("rst_err", int'(err_s[0]), 0);
        check("rst_abc", int'({if0.a, if0.b, if0.cin}), 0);
        #2 rst_n = 1'b1;

        // Correct adder, default settle.
        run_start(0);
        wait_done(0, 1100, n);
        check("clean_cycles", n, 1024);
        check("clean_pass", int'(pass_s[0]), 1);
        check("clean_err", int'(err_s[0]), 0);

        // SUM[0] stuck at 0.
        fault_s[0] = 1;
        run_start(0);
        wait_done(0, 1100, n);
        check("sum0_done", int'(done_s[0]), 1);
        check("sum0_pass", int'(pass_s[0]), 0);
        check("sum0_err", int'(err_s[0]), 256);
`ifdef BIST_FAIL_CAPTURE_EN
        check("cap_valid", int'(fv[0]), 1);
        check("cap_a", int'(fa[0]), 0);
        check("cap_b", int'(fb[0]), 0);
        check("cap_cin", int'(fc[0]), 1);
        check("cap_sum", int'(fs[0]), 0);
        check("cap_carry", int'(fco[0]), 0);
`endif

        // CARRY stuck at 0.
        fault_s[0] = 2;
        run_start(0);
        wait_done(0, 1100, n);
        check("carry_err", int'(err_s[0]), 256);
        check("carry_pass", int'(pass_s[0]), 0);

        // Abort at cycle 100 with SUM[0] fault: vectors 0..49 checked, 25 mismatch.
        fault_s[0] = 1;
        run_start(0);
        repeat (100) @(negedge clk);
        abort_s[0] = 1'b1;
        @(negedge clk);
        abort_s[0] = 1'b0;
        check("abort_busy", int'(busy_s[0]), 0);
        check("abort_done", int'(done_s[0]), 0);
        check("abort_err", int'(err_s[0]), 25);
        fault_s[0] = 0;
        run_start(0);
        wait_done(0, 1100, n);
        check("rerun_cycles", n, 1024);
        check("rerun_pass", int'(pass_s[0]), 1);

        // Reset mid-run at cycle 300.
        run_start(0);
        repeat (300) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("mrst_busy", int'(busy_s[0]), 0);
        check("mrst_done", int'(done_s[0]), 0);
        check("mrst_pass", int'(pass_s[0]), 0);
        check("mrst_err", int'(err_s[0]), 0);
        check("mrst_abc", int'({if0.a, if0.b, if0.cin}), 0);
        @(negedge clk);
        #2 rst_n = 1'b1;
        repeat (20) @(negedge clk);
        check("post_rst_busy", int'(busy_s[0]), 0);
        check("post_rst_done", int'(done_s[0]), 0);

        // SETTLE_CYCLES=3, START re-pulsed mid-run must be ignored.
        run_start(1);
        n = 0;
        while (!done_s[1] && n < 2200) begin
            @(negedge clk);
            n++;
            start_s[1] = (n == 500);
        end
        start_s[1] = 1'b0;
        check("s3_cycles", n, 2048);
        check("s3_pass", int'(pass_s[1]), 1);
        check("s3_err", int'(err_s[1]), 0);

        repeat (2) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
